// File: rtl/alu_arbiter.sv
// Purpose: shares one ALU between two requesters with round-robin grant and a registered result stage with NZCV flags.
// Latency: 1 cycle from the accepting edge to out_valid; back-to-back throughput of one op per cycle.
// Backpressure: both readies drop while the result stage is full and out_ready is low; the held result stays stable.

module alu #(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             cy
);

    logic [WIDTH:0] wide;

    // One extra bit carries the adder carry-out, or the borrow for subtract/compare
    always_comb begin
        wide = '0;
        case (op)
            3'b000:         wide = {1'b0, a} + {1'b0, b};
            3'b001:         wide = {1'b0, a | b};
            3'b100:         wide = {1'b0, a & b};
            3'b101, 3'b111: wide = {1'b0, a} - {1'b0, b};
            3'b110:         wide = {1'b0, a ^ b};
            default:        wide = {1'b0, a} + {1'b0, b};
        endcase
        res = wide[WIDTH-1:0];
        cy  = wide[WIDTH];
    end

endmodule

module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [2:0]       r0_inst,
    input  logic [WIDTH-1:0] r0_da,
    input  logic [WIDTH-1:0] r0_db,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [2:0]       r1_inst,
    input  logic [WIDTH-1:0] r1_da,
    input  logic [WIDTH-1:0] r1_db,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAGW-1:0]  out_src,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_flags,
    output logic             out_wb,
    output logic             out_err
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state, state_nxt;
    logic             last_grant;
    logic             grant0, grant1, can_accept, xfer;
    logic [2:0]       sel_inst, alu_op;
    logic [WIDTH-1:0] sel_a, sel_b, alu_res;
    logic             alu_cy;
    logic             illegal, is_add, is_sub;
    logic [WIDTH-1:0] nxt_data;
    logic [3:0]       nxt_flags;
    logic             nxt_wb;

    // Round-robin grant; readies never look at opcode or operands, and are held low in reset
    always_comb begin
        grant0     = r0_valid & (~r1_valid | last_grant);
        grant1     = r1_valid & (~r0_valid | ~last_grant);
        can_accept = (state == EMPTY) | out_ready;
        r0_ready   = rst_n & grant0 & can_accept;
        r1_ready   = rst_n & grant1 & can_accept;
        xfer       = (r0_valid & r0_ready) | (r1_valid & r1_ready);
    end

    // Operand mux; illegal opcodes are never passed to the ALU, an ADD is issued instead
    always_comb begin
        sel_inst = grant1 ? r1_inst : r0_inst;
        sel_a    = grant1 ? r1_da   : r0_da;
        sel_b    = grant1 ? r1_db   : r0_db;
        illegal  = (sel_inst[2:1] == 2'b01);
        alu_op   = illegal ? 3'b000 : sel_inst;
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .op  (alu_op),
        .a   (sel_a),
        .b   (sel_b),
        .res (alu_res),
        .cy  (alu_cy)
    );

    // NZCV and writeback enable for the selected op; errors report Z only and zero data
    always_comb begin
        is_add       = (alu_op == 3'b000);
        is_sub       = (alu_op == 3'b101) | (alu_op == 3'b111);
        nxt_data     = alu_res;
        nxt_flags[3] = alu_res[WIDTH-1];
        nxt_flags[2] = (alu_res == '0);
        nxt_flags[1] = (is_add | is_sub) & alu_cy;
        nxt_flags[0] = 1'b0;
        if (is_add) begin
            nxt_flags[0] = (sel_a[WIDTH-1] == sel_b[WIDTH-1]) & (alu_res[WIDTH-1] != sel_a[WIDTH-1]);
        end else if (is_sub) begin
            nxt_flags[0] = (sel_a[WIDTH-1] != sel_b[WIDTH-1]) & (alu_res[WIDTH-1] != sel_a[WIDTH-1]);
        end
        nxt_wb = (sel_inst != 3'b111);
        if (illegal) begin
            nxt_data  = '0;
            nxt_flags = 4'b0100;
            nxt_wb    = 1'b0;
        end
    end

    // Result stage occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Fill on a transfer, drain when the consumer takes the result and nothing replaces it
    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        case (state)
            EMPTY: begin
                if (xfer) state_nxt = FULL;
            end
            FULL: begin
                out_valid = 1'b1;
                if (!xfer && out_ready) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Result registers load only on a transfer, so they hold while stalled or idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_src   <= '0;
            out_data  <= '0;
            out_flags <= '0;
            out_wb    <= 1'b0;
            out_err   <= 1'b0;
        end else if (xfer) begin
            out_src   <= TAGW'(grant1);
            out_data  <= nxt_data;
            out_flags <= nxt_flags;
            out_wb    <= nxt_wb;
            out_err   <= illegal;
        end
    end

    // Round-robin pointer moves only when an op is actually accepted; starts so requester 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (xfer) begin
            last_grant <= grant1;
        end
    end

endmodule
